// File: rtl/regalu_core.sv
// Parametrised register file + ALU core with an iterative shift-add multiplier and valid/ready ports.
// Optional macro REGALU_R0_ZERO_EN: register 0 reads as zero and ignores writes.
module regalu_core #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 op,
  input  logic [$clog2(NREGS)-1:0]   rd,
  input  logic [$clog2(NREGS)-1:0]   rs1,
  input  logic [$clog2(NREGS)-1:0]   rs2,
  input  logic                       use_imm,
  input  logic [WIDTH-1:0]           imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_zero,
  output logic                       out_carry
);

  localparam int IW = $clog2(NREGS);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, MULT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [SW-1:0]    cnt;
  logic [IW-1:0]    mul_rd;
  logic             accept;
  logic             mul_done;
  logic             wr_en;
  logic [IW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_done = (state == MULT) && (cnt == SW'(WIDTH - 1));

  // Operand fetch from the register state before the accepting edge
  always_comb begin
    op_a = regs[rs1];
    op_b = use_imm ? imm : regs[rs2];
`ifdef REGALU_R0_ZERO_EN
    if (rs1 == '0) begin
      op_a = '0;
    end else begin
      op_a = regs[rs1];
    end
    if (!use_imm && (rs2 == '0)) begin
      op_b = '0;
    end else begin
      op_b = use_imm ? imm : regs[rs2];
    end
`endif
  end

  // Single-cycle ALU; MUL is handled by the iterative datapath
  always_comb begin
    sum       = {1'b0, op_a} + {1'b0, op_b};
    diff      = {1'b0, op_a} - {1'b0, op_b};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      3'b000: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      3'b001: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
      end
      3'b010:  alu_res = op_a & op_b;
      3'b011:  alu_res = op_a ^ op_b;
      3'b100:  alu_res = op_a | op_b;
      3'b101:  alu_res = op_b;
      3'b110:  alu_res = op_a << op_b[SW-1:0];
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // One shift-add step per MULT cycle, wrapping at WIDTH bits
  always_comb begin
    if (mul_b[cnt]) begin
      acc_next = acc + (mul_a << cnt);
    end else begin
      acc_next = acc;
    end
  end

  // Register-file write port: ALU results on accept, MUL result on its last step
  always_comb begin
    wr_en   = (accept && (op != 3'b111)) || mul_done;
    wr_addr = mul_done ? mul_rd : rd;
    wr_data = mul_done ? acc_next : alu_res;
`ifdef REGALU_R0_ZERO_EN
    if (wr_addr == '0) begin
      wr_en = 1'b0;
    end else begin
      wr_en = (accept && (op != 3'b111)) || mul_done;
    end
`endif
  end

  // Register file storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Control FSM, multiplier state and registered output port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_rd    <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b0;
      out_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
          if (accept) begin
            if (op == 3'b111) begin
              state  <= MULT;
              mul_a  <= op_a;
              mul_b  <= op_b;
              mul_rd <= rd;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              out_valid <= 1'b1;
              out_data  <= alu_res;
              out_zero  <= (alu_res == '0);
              out_carry <= alu_carry;
            end
          end
        end
        MULT: begin
          acc <= acc_next;
          cnt <= cnt + SW'(1);
          if (mul_done) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            out_data  <= acc_next;
            out_zero  <= (acc_next == '0);
            out_carry <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regalu_core.sv
// Directed bench for regalu_core (WIDTH=8, NREGS=4) with a cycle-level reference model
// and literal expectations for the key results.
module tb_regalu_core;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [1:0] rd;
  logic [1:0] rs1;
  logic [1:0] rs2;
  logic       use_imm;
  logic [7:0] imm;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_zero;
  logic       out_carry;

  int n_total = 0;
  int n_pass  = 0;

  regalu_core #(.WIDTH(8), .NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .use_imm(use_imm), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_carry(out_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_regs [4] = '{0, 0, 0, 0};
  int m_valid    = 0;
  int m_data     = 0;
  int m_zero     = 0;
  int m_carry    = 0;
  int m_busy     = 0;
  int m_mul_res  = 0;
  int m_mul_rd   = 0;

  function automatic int m_read(input int idx);
`ifdef REGALU_R0_ZERO_EN
    if (idx == 0) return 0;
`endif
    return m_regs[idx];
  endfunction

  task automatic m_write(input int idx, input int val);
`ifdef REGALU_R0_ZERO_EN
    if (idx == 0) return;
`endif
    m_regs[idx] = val;
  endtask

  function automatic int m_in_ready();
    return ((m_busy == 0) && (!m_valid || out_ready)) ? 1 : 0;
  endfunction

  initial begin
    int a, b, res, cy, rdy;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_valid = 0; m_data = 0; m_zero = 0; m_carry = 0; m_busy = 0;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_write(m_mul_rd, m_mul_res);
          m_valid = 1; m_data = m_mul_res; m_zero = (m_mul_res == 0); m_carry = 0;
        end
      end else begin
        rdy = m_in_ready();
        if (m_valid && out_ready) m_valid = 0;
        if (in_valid && rdy) begin
          a  = m_read(int'(rs1));
          b  = use_imm ? int'(imm) : m_read(int'(rs2));
          cy = 0;
          case (op)
            3'd0: begin res = (a + b) & MASK; cy = (a + b) > MASK; end
            3'd1: begin res = (a - b) & MASK; cy = (a < b); end
            3'd2: res = a & b;
            3'd3: res = a ^ b;
            3'd4: res = a | b;
            3'd5: res = b;
            3'd6: res = (a << (b % W)) & MASK;
            default: res = (a * b) & MASK;
          endcase
          if (op == 3'd7) begin
            m_busy = W; m_mul_res = res; m_mul_rd = int'(rd);
          end else begin
            m_write(int'(rd), res);
            m_valid = 1; m_data = res; m_zero = (res == 0); m_carry = cy;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      check("cmp_in_ready", in_ready, m_in_ready());
      check("cmp_out_valid", out_valid, m_valid);
      if (m_valid) begin
        check("cmp_out_data", out_data, m_data);
        check("cmp_out_zero", out_zero, m_zero);
        check("cmp_out_carry", out_carry, m_carry);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  // Must be called 2 time units after a rising edge.
  task automatic issue(input logic [2:0] o, input logic [1:0] d, input logic [1:0] s1,
                       input logic [1:0] s2, input logic ui, input logic [7:0] im);
    int got;
    got = 0;
    in_valid = 1'b1; op = o; rd = d; rs1 = s1; rs2 = s2; use_imm = ui; imm = im;
    for (int i = 0; i < 40 && got == 0; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #2;
        got = 1;
      end
    end
    in_valid = 1'b0;
    check("issue_timeout", got, 1);
  endtask

  task automatic expect_out(input string name, input logic [7:0] d, input logic z, input logic c);
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_data"}, out_data, d);
    check({name, "_zero"}, out_zero, z);
    check({name, "_carry"}, out_carry, c);
    sync();
  endtask

  task automatic read_reg(input string name, input logic [1:0] idx, input logic [7:0] d);
    issue(3'd5, idx, idx, idx, 1'b0, 8'h00);
    @(negedge clk);
    check(name, out_data, d);
    sync();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; rd = 2'd0; rs1 = 2'd0; rs2 = 2'd0;
    use_imm = 1'b0; imm = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_in_ready", in_ready, 1'b1);
    sync();
    rst_n = 1'b1;
    sync();

    // MOV / ADD with carry
    issue(3'd5, 2'd1, 2'd0, 2'd0, 1'b1, 8'h0F);
    issue(3'd5, 2'd2, 2'd0, 2'd0, 1'b1, 8'hF3);
    issue(3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00);
    expect_out("add", 8'h02, 1'b0, 1'b1);
    read_reg("r3_after_add", 2'd3, 8'h02);

    // SUB zero and borrow
    issue(3'd1, 2'd0, 2'd1, 2'd1, 1'b0, 8'h00);
    expect_out("sub_zero", 8'h00, 1'b1, 1'b0);
    issue(3'd1, 2'd0, 2'd1, 2'd0, 1'b1, 8'h10);
    expect_out("sub_borrow", 8'hFF, 1'b0, 1'b1);

    // MUL latency and result
    issue(3'd7, 2'd3, 2'd1, 2'd0, 1'b1, 8'h11);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("mul_busy_ready", in_ready, 1'b0);
      check("mul_busy_valid", out_valid, 1'b0);
    end
    expect_out("mul", 8'hFF, 1'b0, 1'b0);
    read_reg("r3_after_mul", 2'd3, 8'hFF);

    // Backpressure: second instruction held until out_ready rises
    issue(3'd0, 2'd1, 2'd1, 2'd0, 1'b1, 8'h01);
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd0; rd = 2'd2; rs1 = 2'd2; rs2 = 2'd0; use_imm = 1'b1; imm = 8'h01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_hold_data", out_data, 8'h10);
    end
    sync();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1'b1);
    check("bp_release_data", out_data, 8'h10);
    sync();
    in_valid = 1'b0;
    expect_out("bp_second", 8'hF4, 1'b0, 1'b0);
    read_reg("r2_after_bp", 2'd2, 8'hF4);

    // A model-only MUL with wrap and some logic ops
    issue(3'd7, 2'd2, 2'd2, 2'd2, 1'b0, 8'h00);
    issue(3'd3, 2'd3, 2'd2, 2'd1, 1'b0, 8'h00);
    issue(3'd4, 2'd1, 2'd3, 2'd0, 1'b1, 8'h81);
    issue(3'd2, 2'd3, 2'd1, 2'd0, 1'b1, 8'h3C);

    // Reset during the third MULT cycle aborts the multiply
    issue(3'd7, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midmul_rst_valid", out_valid, 1'b0);
    check("midmul_rst_ready", in_ready, 1'b1);
    check("midmul_rst_data", out_data, 8'h00);
    sync();
    sync();
    rst_n = 1'b1;
    sync();
    issue(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05);
    expect_out("post_rst_add", 8'h05, 1'b0, 1'b0);
    read_reg("r2_after_rst", 2'd2, 8'h00);
    read_reg("r3_after_rst", 2'd3, 8'h00);

    // Shift amount uses only the low bits of B (0x0B -> 3)
    issue(3'd6, 2'd2, 2'd1, 2'd0, 1'b1, 8'h0B);
    expect_out("shl", 8'h28, 1'b0, 1'b0);

    // Register 0 behaviour
    issue(3'd5, 2'd0, 2'd0, 2'd0, 1'b1, 8'hAA);
    expect_out("mov_r0", 8'hAA, 1'b0, 1'b0);
    issue(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h01);
`ifdef REGALU_R0_ZERO_EN
    expect_out("r0_add", 8'h01, 1'b0, 1'b0);
`else
    expect_out("r0_add", 8'hAB, 1'b0, 1'b0);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regalu_core.md
Name: regalu_core

Overview:
- Parametrised register-file + ALU execution core; successor to the fixed 8-bit, 2-register, 4-op datapath.
- Accepts one instruction per valid/ready handshake and reads two source registers (or an immediate).
- Computes the result, writes it back to a destination register, and presents the result plus flags on a valid/ready output port.
- Adds an iterative multiply, carry/zero flags and output backpressure.

Parameters:
- WIDTH, 8, data/register width in bits (>=4).
- NREGS, 4, number of registers; power of two, >=2; index width IW = $clog2(NREGS).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction present
- in_ready  out  1  core can accept an instruction this cycle
- op  in  3  opcode (see Behaviour)
- rd  in  IW  destination register index
- rs1  in  IW  source A index
- rs2  in  IW  source B index
- use_imm  in  1  1: operand B = imm instead of reg[rs2]
- imm  in  WIDTH  immediate operand
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  result value
- out_zero  out  1  result == 0
- out_carry  out  1  ADD carry-out / SUB borrow; 0 for all other ops

Behaviour:
- Reset (async, rst_n=0): all registers 0, state IDLE, out_valid=0, out_data=0, out_zero=0, out_carry=0. in_ready is 1 once reset deasserts. Reset mid-multiply aborts it with no write-back.
- Accept: accept = in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Opcodes: A = reg[rs1]; B = use_imm ? imm : reg[rs2].
  - 000 ADD: A+B; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - 001 SUB: A-B; carry = borrow (A<B unsigned).
  - 010 AND.
  - 011 XOR.
  - 100 OR.
  - 101 MOV: result = B.
  - 110 SHL: A << B[$clog2(WIDTH)-1:0], zero fill.
  - 111 MUL: low WIDTH bits of A*B, unsigned.
- Single-cycle ops (000-110): on the accepting edge, reg[rd] <= result, out_data/out_zero/out_carry <= result/flags, out_valid <= 1. Latency is 1 cycle. Back-to-back issue is supported.
- Operands are read combinationally from the register state before the accepting edge. rd==rs1/rs2 therefore uses the old value, and the new value is visible to the next instruction.
- MUL FSM:
  - On accept, go IDLE->MULT. Capture A, B and rd; acc=0; cnt=0.
  - Each MULT cycle: if B[cnt], acc += A<<cnt (WIDTH bits, wrap); cnt++.
  - After WIDTH cycles (cnt==WIDTH-1 processed), write reg[rd] <= acc, out_data <= acc, out_valid <= 1, out_carry <= 0, and return to IDLE.
  - Total latency is WIDTH cycles from the accepting edge to out_valid=1. in_ready=0 throughout MULT.
- Output handshake:
  - out_valid stays high with stable out_data/flags until out_valid && out_ready.
  - Accept and output handshake in the same cycle: the new result replaces the old one and out_valid stays 1.
  - Result handshaken with no new result pending: out_valid <= 0.
  - While out_valid && !out_ready, in_ready=0 and the register file is not written.
- All arithmetic is modulo 2^WIDTH. out_zero is computed on the truncated WIDTH-bit result.
- in_valid while in_ready=0: instruction ignored; the upstream holds it.

Optional Feature:
- Macro: REGALU_R0_ZERO_EN.
- Defined:
  - reg[0] is hardwired to 0: reads return 0, writes to rd=0 are discarded.
  - The result is still presented on out_* (discard-destination semantics).
- Undefined: reg[0] is an ordinary writable register.

Test Plan:
- WIDTH=8, NREGS=4. Reset, then MOV r1<-imm 0x0F, MOV r2<-imm 0xF3, ADD r3=r1+r2 -> out_data=0x02, out_carry=1, out_zero=0; r3=0x02.
- SUB r0=r1-r1 -> out_data=0x00, out_zero=1, out_carry=0. SUB r0=r1-imm 0x10 -> 0xFF, carry=1.
- MUL r3=r1*imm 0x11 (0x0F*0x11=0xFF) -> in_ready=0 for 8 cycles, out_valid rises exactly 8 cycles after accept, out_data=0xFF, r3=0xFF.
- Backpressure: hold out_ready=0 after ADD -> in_ready=0, out_data stable, a second instruction is not accepted and not written. Raise out_ready -> the second instruction is accepted that cycle and its result appears next cycle.
- Assert rst_n=0 on cycle 3 of a MUL -> out_valid=0 immediately, all registers 0, state IDLE. After release, ADD r1=r0+imm 5 gives 0x05.
- With REGALU_R0_ZERO_EN: MOV r0<-imm 0xAA -> out_data=0xAA, then ADD r1=r0+imm 1 -> 0x01. Without the macro the same sequence gives 0xAB.
